systolic_skew_feeder: RTL and testbench

Upstream operand stage for the 5x5 output-stationary PE array. It holds one A matrix and one B matrix in local register buffers, loaded through a simple write port. On `start` it streams them into the array's row inputs (a lanes) and column inputs (b lanes) with the diagonal skew the array requires. It then drives zeros for a drain period and pulses `done`, replacing the fixed-pattern data controller with a loadable one.

---
 rtl/systolic_pkg.sv | 31 +++
 rtl/systolic_skew_feeder_if.sv | 36 +++
 rtl/systolic_skew_feeder_matrix_buf.sv | 43 ++++
 rtl/systolic_skew_feeder.sv | 129 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic skew feeder.
// Holds the array geometry, operand width, drain length, the feeder
// state encoding, the counter width and a helper that extracts one
// DW-wide lane from an N-lane flattened bus.
package systolic_pkg;

    localparam int N     = 5;   // array dimension
    localparam int DW    = 8;   // operand width
    localparam int DRAIN = 5;   // zero cycles after the last skewed operand

    // Cycle counter covers t = 0 .. 2N-1+DRAIN.
    localparam int CNT_W = $clog2(2 * N + DRAIN);

    // Last t of each phase.
    localparam int STREAM_LAST = 2 * N - 2;
    localparam int DRAIN_LAST  = 2 * N - 2 + DRAIN;
    localparam int FIN_T       = 2 * N - 1 + DRAIN;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    // Lane k of an N-lane bus is bits [k*DW +: DW].
    function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] bus, input int k);
        return bus[k*DW +: DW];
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Connection bundle between the feeder and its environment.
//   wr_en/wr_sel/wr_row/wr_col/wr_data : buffer write port (into feeder)
//   start                              : begin streaming (into feeder)
//   busy/done                          : stream status (from feeder)
//   a_bus/b_bus                        : skewed row / column operands (from feeder)
//   state_dbg                          : current controller state (from feeder)
// Write/start semantics: a write is taken on any rising edge where wr_en
// is high while the feeder is idle and the address is in range; start is
// taken on a rising edge only while idle and wr_en is low. There is no
// back-pressure on the operand buses.
interface systolic_skew_feeder_if;
    import systolic_pkg::*;

    logic              wr_en;
    logic              wr_sel;
    logic [2:0]        wr_row;
    logic [2:0]        wr_col;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic              busy;
    logic              done;
    logic [N*DW-1:0]   a_bus;
    logic [N*DW-1:0]   b_bus;
    state_t            state_dbg;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, done, a_bus, b_bus, state_dbg
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, done, a_bus, b_bus, state_dbg
    );

endinterface

// File: rtl/systolic_skew_feeder_matrix_buf.sv
// N x N x DW register file with one write port and a flattened read bus.
//   clk, rst        : clock, async active-high clear of every entry
//   wr_en           : write strobe (address already range-checked by caller)
//   wr_row, wr_col  : element address
//   wr_data         : element value
//   rd_bus          : all entries, element (r,c) at [(r*N+c)*DW +: DW]
module matrix_buf
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_row,
    input  logic [2:0]        wr_col,
    input  logic [DW-1:0]     wr_data,
    output logic [N*N*DW-1:0] rd_bus
);

    logic [DW-1:0] mem [N*N];
    int            wr_idx;

    always_comb begin
        wr_idx = int'(wr_row) * N + int'(wr_col);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N * N; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_bus = '0;
        for (int k = 0; k < N * N; k++) begin
            rd_bus[k*DW +: DW] = mem[k];
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Loadable operand feeder for the N x N output-stationary PE array.
// Holds one A and one B matrix; on start it streams A rows and B columns
// with diagonal skew, drives zeros for DRAIN cycles, then pulses done.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset (also clears both buffers)
//   bus  : write port, start, busy/done and the a/b operand buses
module systolic_skew_feeder
    import systolic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    systolic_skew_feeder_if.slave bus
);

    state_t             state;
    state_t             st_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   t_nxt;
    logic               busy_q;
    logic               done_q;
    logic [N*DW-1:0]    a_q;
    logic [N*DW-1:0]    b_q;
    logic [N*DW-1:0]    a_nxt;
    logic [N*DW-1:0]    b_nxt;
    logic [N*N*DW-1:0]  a_rd;
    logic [N*N*DW-1:0]  b_rd;
    logic               wr_ok;
    int                 tt;

    // Buffers are frozen outside IDLE so a replay sees identical data.
    assign wr_ok = (state == S_IDLE) && bus.wr_en
                   && (bus.wr_row < 3'(N)) && (bus.wr_col < 3'(N));

    matrix_buf u_a_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && !bus.wr_sel),
        .wr_row  (bus.wr_row),
        .wr_col  (bus.wr_col),
        .wr_data (bus.wr_data),
        .rd_bus  (a_rd)
    );

    matrix_buf u_b_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && bus.wr_sel),
        .wr_row  (bus.wr_row),
        .wr_col  (bus.wr_col),
        .wr_data (bus.wr_data),
        .rd_bus  (b_rd)
    );

    // Next state and next t. Outputs are registered from the *next* t so
    // the t = 0 operands appear on the same edge that leaves IDLE.
    always_comb begin
        st_nxt = state;
        t_nxt  = cnt;
        case (state)
            S_IDLE: begin
                t_nxt = '0;
                if (bus.start && !bus.wr_en) begin
                    st_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                t_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(STREAM_LAST)) begin
                    st_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                t_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DRAIN_LAST)) begin
                    st_nxt = S_FIN;
                end
            end
            S_FIN: begin
                st_nxt = S_IDLE;
                t_nxt  = '0;
            end
            default: begin
                st_nxt = S_IDLE;
                t_nxt  = '0;
            end
        endcase
    end

    // Skew selection: row lane i carries A[i][t-i], column lane j carries
    // B[t-j][j], each only inside its N-cycle window.
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        tt    = int'(t_nxt);
        if (st_nxt == S_STREAM) begin
            for (int i = 0; i < N; i++) begin
                if (tt >= i && tt <= i + N - 1) begin
                    a_nxt[i*DW +: DW] = lane(a_rd[i*N*DW +: N*DW], tt - i);
                    b_nxt[i*DW +: DW] = lane(b_rd[(tt-i)*N*DW +: N*DW], i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            state  <= st_nxt;
            cnt    <= t_nxt;
            busy_q <= (st_nxt == S_STREAM) || (st_nxt == S_DRAIN);
            done_q <= (st_nxt == S_FIN);
            a_q    <= a_nxt;
            b_q    <= b_nxt;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.a_bus     = a_q;
    assign bus.b_bus     = b_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
    import systolic_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic check_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    systolic_skew_feeder_if bus();

    systolic_skew_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // mt is the stream time t (-1 when idle); matrices mirror accepted writes.
    int ma [N][N];
    int mb [N][N];
    int mt = -1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ma[i][j] <= 0;
                    mb[i][j] <= 0;
                end
            mt <= -1;
        end else if (mt < 0) begin
            if (bus.wr_en) begin
                if (int'(bus.wr_row) < N && int'(bus.wr_col) < N) begin
                    if (bus.wr_sel) mb[bus.wr_row][bus.wr_col] <= int'(bus.wr_data);
                    else            ma[bus.wr_row][bus.wr_col] <= int'(bus.wr_data);
                end
            end else if (bus.start) begin
                mt <= 0;
            end
        end else if (mt == 2 * N - 1 + DRAIN) begin
            mt <= -1;
        end else begin
            mt <= mt + 1;
        end
    end

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        logic [N*DW-1:0] ea;
        logic [N*DW-1:0] eb;
        logic            eb_busy;
        logic            eb_done;
        if (check_en && !rst) begin
            ea = '0;
            eb = '0;
            eb_busy = (mt >= 0) && (mt <= 2 * N - 2 + DRAIN);
            eb_done = (mt == 2 * N - 1 + DRAIN);
            for (int i = 0; i < N; i++) begin
                if (mt >= i && mt <= i + N - 1) begin
                    ea[i*DW +: DW] = DW'(ma[i][mt-i]);
                    eb[i*DW +: DW] = DW'(mb[mt-i][i]);
                end
            end
            chk("model_busy", {{(N*DW-1){1'b0}}, bus.busy}, {{(N*DW-1){1'b0}}, eb_busy});
            chk("model_done", {{(N*DW-1){1'b0}}, bus.done}, {{(N*DW-1){1'b0}}, eb_done});
            chk("model_a_bus", bus.a_bus, ea);
            chk("model_b_bus", bus.b_bus, eb);
        end
    end

    // ---------------- driver tasks (entered just after a negedge) ----------------
    task automatic wr(input logic sel, input int r, input int c, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = 3'(r);
        bus.wr_col  = 3'(c);
        bus.wr_data = DW'(d);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Leaves the caller at the negedge of stream cycle t = 0.
    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits for done (bounded) and returns the cycle count it took.
    task automatic wait_done(output int waited);
        waited = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) begin
                waited = k;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (waited < 0) begin
            miscompares++;
            $display("FAIL wait_done: got timeout expected done pulse");
        end
        @(negedge clk);
    endtask

    function automatic logic [N*DW-1:0] mk(input int v0, input int v1, input int v2, input int v3, input int v4);
        return {DW'(v4), DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
    endfunction

    function automatic logic [N*DW-1:0] b1(input logic v);
        return {{(N*DW-1){1'b0}}, v};
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        int busy_cnt;
        int done_cnt;
        int done_t;
        int w;

        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_data = '0; bus.start = 1'b0;

        #12;
        chk("reset_busy", b1(bus.busy), b1(1'b0));
        chk("reset_done", b1(bus.done), b1(1'b0));
        chk("reset_a", bus.a_bus, '0);
        chk("reset_b", bus.b_bus, '0);
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        @(negedge clk);

        // Scenario 1: A[i][j] = 10i+j+1, B = identity.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wr(1'b0, i, j, 10 * i + j + 1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wr(1'b1, i, j, (i == j) ? 1 : 0);
        do_start();
        busy_cnt = 0; done_cnt = 0; done_t = -1;
        for (int t = 0; t < 20; t++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin done_cnt++; done_t = t; end
            if (t == 0) begin
                chk("t0_a", bus.a_bus, mk(1, 0, 0, 0, 0));
                chk("t0_b", bus.b_bus, mk(1, 0, 0, 0, 0));
            end
            if (t == 4) begin
                chk("t4_a", bus.a_bus, mk(5, 14, 23, 32, 41));
                chk("t4_b", bus.b_bus, mk(0, 0, 1, 0, 0));
            end
            if (t == 8) chk("t8_a", bus.a_bus, mk(0, 0, 0, 0, 45));
            if (t >= 9 && t <= 14) begin
                chk("drain_a", bus.a_bus, '0);
                chk("drain_b", bus.b_bus, '0);
            end
            @(negedge clk);
        end
        chk("busy_cycles", 40'(busy_cnt), 40'(14));
        chk("done_pulses", 40'(done_cnt), 40'(1));
        chk("done_time", 40'(done_t), 40'(14));

        // Scenario 2: writes during busy and out-of-range writes are dropped.
        do_start();
        wr(1'b0, 0, 0, 8'hFF);
        wr(1'b0, 5, 0, 8'hAA);
        wr(1'b0, 0, 7, 8'hBB);
        wait_done(w);
        wr(1'b0, 5, 1, 8'hCC);
        wr(1'b1, 2, 7, 8'hDD);
        do_start();
        chk("replay_a0", {32'd0, lane(bus.a_bus, 0)}, 40'd1);
        wait_done(w);

        // Scenario 3: start together with wr_en -> write only.
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = 3'd0; bus.wr_col = 3'd0;
        bus.wr_data = 8'h77; bus.start = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.start = 1'b0;
        chk("start_with_wr_busy", b1(bus.busy), b1(1'b0));
        do_start();
        chk("new_value_a0", {32'd0, lane(bus.a_bus, 0)}, 40'h77);
        wait_done(w);

        // Scenario 4: reset at t = 6 aborts and clears.
        do_start();
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", b1(bus.busy), b1(1'b0));
        chk("abort_done", b1(bus.done), b1(1'b0));
        chk("abort_a", bus.a_bus, '0);
        chk("abort_b", bus.b_bus, '0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        do_start();
        repeat (4) @(negedge clk);
        chk("cleared_t4_a", bus.a_bus, '0);
        repeat (10) @(negedge clk);
        chk("cleared_done_t14", b1(bus.done), b1(1'b1));
        @(negedge clk);

        // Scenario 5: starts at t = 3 and in FIN are ignored; after FIN accepted.
        wr(1'b0, 0, 0, 8'h11);
        do_start();
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("fin_done_t14", b1(bus.done), b1(1'b1));
        bus.start = 1'b1;
        @(negedge clk);
        chk("after_fin_idle", b1(bus.busy), b1(1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_busy", b1(bus.busy), b1(1'b1));
        chk("restart_a0", {32'd0, lane(bus.a_bus, 0)}, 40'h11);
        wait_done(w);
        chk("restart_done_t14", 40'(w), 40'(14));

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
